// File: rtl/branch_predictor_gshare_pkg.sv
// Package bp_pkg: shared definitions for the gshare branch predictor.
//   S_INIT / S_RUN : controller state encoding
//   cnt_init()     : weakly-not-taken counter start value for a given width
//   sat_update()   : saturating +1 / -1 on a counter of a given width
package bp_pkg;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Widest counter the helper functions handle.
    localparam int CNT_MAX_W = 16;

    function automatic int cnt_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic logic [CNT_MAX_W-1:0] sat_update(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 taken,
        input int                   cnt_w
    );
        logic [CNT_MAX_W-1:0] cmax;
        cmax = CNT_MAX_W'((1 << cnt_w) - 1);
        if (taken)
            return (cnt == cmax) ? cnt : cnt + 1'b1;
        else
            return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Interface bundling the fetch-side lookup, prediction result and
// execute-side update signals of the branch predictor.
//   master : fetch/execute pipeline (drives lookup and update)
//   slave  : predictor (drives ready and prediction)
interface branch_predictor_gshare_if #(
    parameter int IDX_W  = 5,
    parameter int HIST_W = 5
);
    logic              lookup_valid;
    logic [IDX_W-1:0]  lookup_pc_idx;
    logic              ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic [HIST_W-1:0] pred_ghr;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              upd_mispredict;
    logic [HIST_W-1:0] upd_ghr;

    modport master (
        output lookup_valid, lookup_pc_idx,
        output upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
        input  ready, pred_valid, pred_taken, pred_idx, pred_ghr
    );

    modport slave (
        input  lookup_valid, lookup_pc_idx,
        input  upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
        output ready, pred_valid, pred_taken, pred_idx, pred_ghr
    );
endinterface

// File: rtl/branch_predictor_gshare_pht_ram.sv
// bp_pht_ram: pattern history table storage, 2**IDX_W x CNT_W.
//   clk      : write clock
//   we       : write enable
//   waddr    : write index
//   wdata    : counter value to store
//   raddr_a  : read index A (update path), rdata_a combinational
//   raddr_b  : read index B (lookup path),  rdata_b combinational
module bp_pht_ram #(
    parameter int IDX_W = 5,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [CNT_W-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [CNT_W-1:0] rdata_b
);
    logic [CNT_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: gshare / bimodal dynamic branch predictor.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; restarts the PHT init sweep
//   bp  : slave side of branch_predictor_gshare_if (lookup, prediction, update)
//
// state  | meaning
// S_INIT | sweeping PHT to weakly-not-taken, one entry per cycle; ready=0
// S_RUN  | serving lookups and updates; ready=1
module branch_predictor_gshare import bp_pkg::*; #(
    parameter int IDX_W     = 5,
    parameter int CNT_W     = 2,
    parameter int HIST_W    = 5,
    parameter bit GSHARE_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    branch_predictor_gshare_if.slave  bp
);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(2**IDX_W - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [HIST_W-1:0] ghr;
    logic              run;
    logic              upd_en;
    logic              lk_en;
    logic [IDX_W-1:0]  lk_idx;
    logic [CNT_W-1:0]  upd_cnt;
    logic [CNT_W-1:0]  upd_cnt_new;
    logic [CNT_W-1:0]  lk_cnt_raw;
    logic              lk_taken;
    logic [HIST_W-1:0] ghr_lk;
    logic [HIST_W-1:0] ghr_rs;
    logic              pht_we;
    logic [IDX_W-1:0]  pht_waddr;
    logic [CNT_W-1:0]  pht_wdata;
    logic              pred_valid_q;
    logic              pred_taken_q;
    logic [IDX_W-1:0]  pred_idx_q;
    logic [HIST_W-1:0] pred_ghr_q;
    logic              unused_bits;

    assign run    = (state == S_RUN);
    assign upd_en = run & bp.upd_valid;
    assign lk_en  = run & bp.lookup_valid;

    generate
        if (GSHARE_EN) begin : g_hash
            assign lk_idx = bp.lookup_pc_idx ^ IDX_W'(ghr);
        end else begin : g_bimodal
            assign lk_idx = bp.lookup_pc_idx;
        end

        if (HIST_W == 1) begin : g_hist1
            assign ghr_lk = lk_taken;
            assign ghr_rs = bp.upd_taken;
        end else begin : g_histn
            assign ghr_lk = {ghr[HIST_W-2:0], lk_taken};
            assign ghr_rs = {bp.upd_ghr[HIST_W-2:0], bp.upd_taken};
        end
    endgenerate

    assign upd_cnt_new = CNT_W'(sat_update(CNT_MAX_W'(upd_cnt), bp.upd_taken, CNT_W));

    // Write-first: a lookup hitting the entry being updated sees the new value.
    assign lk_taken = (upd_en && (bp.upd_idx == lk_idx)) ? upd_cnt_new[CNT_W-1]
                                                         : lk_cnt_raw[CNT_W-1];

    // The sweep owns the write port during INIT; updates own it during RUN.
    assign pht_we    = !rst && (!run || upd_en);
    assign pht_waddr = run ? bp.upd_idx : ptr;
    assign pht_wdata = run ? upd_cnt_new : CNT_INIT;

    bp_pht_ram #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_pht (
        .clk     (clk),
        .we      (pht_we),
        .waddr   (pht_waddr),
        .wdata   (pht_wdata),
        .raddr_a (bp.upd_idx),
        .rdata_a (upd_cnt),
        .raddr_b (lk_idx),
        .rdata_b (lk_cnt_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_INIT;
            ptr          <= '0;
            ghr          <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_ghr_q   <= '0;
        end else begin
            if (!run) begin
                ptr <= ptr + 1'b1;
                if (ptr == PTR_LAST)
                    state <= S_RUN;
            end

            pred_valid_q <= lk_en;
            if (lk_en) begin
                pred_taken_q <= lk_taken;
                pred_idx_q   <= lk_idx;
                pred_ghr_q   <= ghr;
            end

            // Mispredict recovery wins over the speculative shift.
            if (upd_en && bp.upd_mispredict)
                ghr <= ghr_rs;
            else if (lk_en)
                ghr <= ghr_lk;
        end
    end

    assign bp.ready      = run;
    assign bp.pred_valid = pred_valid_q;
    assign bp.pred_taken = pred_taken_q;
    assign bp.pred_idx   = pred_idx_q;
    assign bp.pred_ghr   = pred_ghr_q;

    // Only counter MSBs and the low history bits feed logic.
    assign unused_bits = ^{lk_cnt_raw, bp.upd_ghr};
endmodule

// File: tb/tb_branch_predictor_gshare.sv
module tb_branch_predictor_gshare;

    typedef struct packed {
        logic [4:0] idx;
        logic       taken;
        logic [4:0] ghr;
    } exp_t;

    typedef struct packed {
        int   n;
        logic dir;
        logic look;
        logic exp_tk;
    } step_t;

    typedef struct packed {
        logic       lv;
        logic [4:0] pc;
        logic       uv;
        logic [4:0] ui;
        logic       ut;
        logic       um;
        logic [4:0] ug;
        logic [4:0] exp_idx;
        logic [4:0] exp_ghr;
        logic       exp_tk;
    } gstep_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // d=0: bimodal CNT_W=2, d=1: gshare CNT_W=2, d=2: bimodal CNT_W=3
    int   cnt_m [3][32];
    logic [4:0] ghr_m [3];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    branch_predictor_gshare_if #(.IDX_W(5), .HIST_W(5)) if_a ();
    branch_predictor_gshare_if #(.IDX_W(5), .HIST_W(5)) if_g ();
    branch_predictor_gshare_if #(.IDX_W(5), .HIST_W(5)) if_c ();

    branch_predictor_gshare #(.IDX_W(5), .CNT_W(2), .HIST_W(5), .GSHARE_EN(1'b0))
        dut_a (.clk(clk), .rst(rst), .bp(if_a));
    branch_predictor_gshare #(.IDX_W(5), .CNT_W(2), .HIST_W(5), .GSHARE_EN(1'b1))
        dut_g (.clk(clk), .rst(rst), .bp(if_g));
    branch_predictor_gshare #(.IDX_W(5), .CNT_W(3), .HIST_W(5), .GSHARE_EN(1'b0))
        dut_c (.clk(clk), .rst(rst), .bp(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 32; i++) cnt_m[d][i] = (d == 2) ? 3 : 1;
            ghr_m[d] = '0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Drives one cycle of stimulus on DUT d and advances the reference model.
    task automatic drive(input int d, input logic lv, input logic [4:0] pc,
                         input logic uv, input logic [4:0] ui, input logic ut,
                         input logic um, input logic [4:0] ug);
        int nv;
        int w;
        int val;
        logic [4:0] idx;
        exp_t e;
        e  = '0;
        w  = (d == 2) ? 3 : 2;
        nv = cnt_m[d][ui];
        if (uv) nv = ut ? ((nv == (1 << w) - 1) ? nv : nv + 1) : ((nv == 0) ? 0 : nv - 1);
        if (lv) begin
            idx     = (d == 1) ? (pc ^ ghr_m[d]) : pc;
            val     = (uv && ui == idx) ? nv : cnt_m[d][idx];
            e.idx   = idx;
            e.taken = (val >= (1 << (w - 1)));
            e.ghr   = ghr_m[d];
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        if (uv) cnt_m[d][ui] = nv;
        if (uv && um) ghr_m[d] = {ug[3:0], ut};
        else if (lv)  ghr_m[d] = {ghr_m[d][3:0], e.taken};
        case (d)
            0: begin
                if_a.lookup_valid = lv; if_a.lookup_pc_idx = pc; if_a.upd_valid = uv;
                if_a.upd_idx = ui; if_a.upd_taken = ut; if_a.upd_mispredict = um; if_a.upd_ghr = ug;
            end
            1: begin
                if_g.lookup_valid = lv; if_g.lookup_pc_idx = pc; if_g.upd_valid = uv;
                if_g.upd_idx = ui; if_g.upd_taken = ut; if_g.upd_mispredict = um; if_g.upd_ghr = ug;
            end
            default: begin
                if_c.lookup_valid = lv; if_c.lookup_pc_idx = pc; if_c.upd_valid = uv;
                if_c.upd_idx = ui; if_c.upd_taken = ut; if_c.upd_mispredict = um; if_c.upd_ghr = ug;
            end
        endcase
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic read_out(input int d, output logic pv, output logic pt,
                            output logic [4:0] pi, output logic [4:0] pg, output logic rdy);
        case (d)
            0: begin pv = if_a.pred_valid; pt = if_a.pred_taken; pi = if_a.pred_idx; pg = if_a.pred_ghr; rdy = if_a.ready; end
            1: begin pv = if_g.pred_valid; pt = if_g.pred_taken; pi = if_g.pred_idx; pg = if_g.pred_ghr; rdy = if_g.ready; end
            default: begin pv = if_c.pred_valid; pt = if_c.pred_taken; pi = if_c.pred_idx; pg = if_c.pred_ghr; rdy = if_c.ready; end
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        e  = '0;
        ok = 1'b0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic run_updates(input int d, input logic [4:0] idx, input int n, input logic dir);
        for (int k = 0; k < n; k++) begin
            drive(d, 1'b0, 5'd0, 1'b1, idx, dir, 1'b0, 5'd0);
            @(negedge clk);
        end
        idle_all();
    endtask

    // Holds rst, releases it, and returns the number of cycles ready stays low.
    task automatic reset_and_count(input int hold, output int cycles);
        rst = 1'b1;
        idle_all();
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycles = 0;
        while (if_a.ready === 1'b0 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic pv, pt, rdy;
        logic [4:0] pi, pg;
        int cycles;
        bit seen_pv;
        rst = 1'b1;
        idle_all();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            read_out(d, pv, pt, pi, pg, rdy);
            n_checks++;
            if ({pv, pt, pi, pg, rdy} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got v=%b t=%b idx=%0d ghr=%b rdy=%b, want all 0", d, pv, pt, pi, pg, rdy);
            end
        end
        rst = 1'b0;
        model_reset();
        // Traffic during the sweep must be ignored.
        if_a.lookup_valid = 1'b1; if_a.lookup_pc_idx = 5'd5;
        if_g.upd_valid = 1'b1; if_g.upd_mispredict = 1'b1; if_g.upd_taken = 1'b1; if_g.upd_ghr = 5'b11111;
        if_g.lookup_valid = 1'b1;
        cycles  = 0;
        seen_pv = 1'b0;
        while (if_a.ready === 1'b0 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (if_a.pred_valid !== 1'b0 || if_g.pred_valid !== 1'b0) seen_pv = 1'b1;
        end
        idle_all();
        n_checks++;
        if (cycles != 32) begin
            n_fail++;
            $display("FAIL init_sweep_len: got %0d cycles of ready=0, want 32", cycles);
        end
        n_checks++;
        if (seen_pv) begin
            n_fail++;
            $display("FAIL init_lookup_ignored: got pred_valid=1 during sweep, want 0");
        end
        n_checks++;
        if (if_g.ready !== 1'b1 || if_c.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_sweep: got g=%b c=%b, want 1 1", if_g.ready, if_c.ready);
        end
    endtask

    task automatic test_first_lookup();
        logic pv, pt, rdy;
        logic [4:0] pi, pg;
        exp_t e;
        bit ok;
        for (int i = 0; i <= 32; i++) begin
            if (i > 0) begin
                read_out(0, pv, pt, pi, pg, rdy);
                pop_exp(0, e, ok);
                n_checks++;
                if (!ok || pv !== 1'b1 || pt !== 1'b0 || pi !== e.idx || pg !== e.ghr) begin
                    n_fail++;
                    $display("FAIL first_lookup idx %0d: got v=%b t=%b idx=%0d ghr=%b, want v=1 t=0 idx=%0d ghr=%b", i-1, pv, pt, pi, pg, e.idx, e.ghr);
                end
            end
            if (i < 32) drive(0, 1'b1, 5'(i), 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            else        idle_all();
            @(negedge clk);
        end
        n_checks++;
        if (if_a.pred_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pred_valid_drop: got %b, want 0", if_a.pred_valid);
        end
    endtask

    // Table of update bursts, each optionally followed by a lookup of idx.
    task automatic run_steps(input string name, input int d, input logic [4:0] idx,
                             input step_t st[8], input int n);
        logic pv, pt, rdy;
        logic [4:0] pi, pg;
        exp_t e;
        bit ok;
        for (int s = 0; s < n; s++) begin
            run_updates(d, idx, st[s].n, st[s].dir);
            if (st[s].look) begin
                drive(d, 1'b1, idx, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
                @(negedge clk);
                idle_all();
                read_out(d, pv, pt, pi, pg, rdy);
                pop_exp(d, e, ok);
                n_checks++;
                if (!ok || pv !== 1'b1 || pt !== st[s].exp_tk || pt !== e.taken || pi !== idx || pg !== e.ghr) begin
                    n_fail++;
                    $display("FAIL %s step %0d: got v=%b t=%b idx=%0d ghr=%b, want v=1 t=%b idx=%0d ghr=%b", name, s, pv, pt, pi, pg, st[s].exp_tk, idx, e.ghr);
                end
            end
        end
    endtask

    task automatic test_train();
        step_t st[8];
        st[0] = '{2, 1'b1, 1'b1, 1'b1};
        st[1] = '{5, 1'b1, 1'b1, 1'b1};
        st[2] = '{1, 1'b0, 1'b1, 1'b1};
        st[3] = '{1, 1'b0, 1'b1, 1'b0};
        for (int i = 4; i < 8; i++) st[i] = '{0, 1'b0, 1'b0, 1'b0};
        run_steps("train_idx3", 0, 5'd3, st, 4);
    endtask

    task automatic test_cnt3();
        step_t st[8];
        st[0] = '{0,  1'b0, 1'b1, 1'b0};
        st[1] = '{1,  1'b1, 1'b1, 1'b1};
        st[2] = '{10, 1'b1, 1'b0, 1'b0};
        st[3] = '{3,  1'b0, 1'b1, 1'b1};
        st[4] = '{1,  1'b0, 1'b1, 1'b0};
        st[5] = '{10, 1'b0, 1'b0, 1'b0};
        st[6] = '{3,  1'b1, 1'b1, 1'b0};
        st[7] = '{1,  1'b1, 1'b1, 1'b1};
        run_steps("cnt3_sat", 2, 5'd10, st, 8);
    endtask

    task automatic test_bypass();
        logic pv, pt, rdy;
        logic [4:0] pi, pg;
        exp_t e;
        bit ok;
        logic [4:0] lk_pc [4];
        logic [4:0] up_ix [4];
        logic       up_dir [4];
        logic       want [4];
        lk_pc = '{5'd7, 5'd9, 5'd8, 5'd7};
        up_ix = '{5'd7, 5'd8, 5'd0, 5'd7};
        up_dir = '{1'b1, 1'b1, 1'b0, 1'b0};
        want  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 4; s++) begin
            drive(0, 1'b1, lk_pc[s], (s != 2), up_ix[s], up_dir[s], 1'b0, 5'd0);
            @(negedge clk);
            idle_all();
            read_out(0, pv, pt, pi, pg, rdy);
            pop_exp(0, e, ok);
            n_checks++;
            if (!ok || pv !== 1'b1 || pt !== want[s] || pi !== lk_pc[s] || pg !== e.ghr) begin
                n_fail++;
                $display("FAIL bypass step %0d: got v=%b t=%b idx=%0d ghr=%b, want v=1 t=%b idx=%0d ghr=%b", s, pv, pt, pi, pg, want[s], lk_pc[s], e.ghr);
            end
        end
    endtask

    task automatic test_gshare();
        logic pv, pt, rdy;
        logic [4:0] pi, pg;
        exp_t e;
        bit ok;
        gstep_t g[10];
        g[0] = '{1'b0, 5'd0, 1'b1, 5'd0,  1'b1, 1'b0, 5'd0,     5'd0, 5'd0,     1'b0};
        g[1] = '{1'b0, 5'd0, 1'b1, 5'd1,  1'b1, 1'b0, 5'd0,     5'd0, 5'd0,     1'b0};
        g[2] = '{1'b0, 5'd0, 1'b1, 5'd3,  1'b1, 1'b0, 5'd0,     5'd0, 5'd0,     1'b0};
        g[3] = '{1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,     5'd0, 5'b00000, 1'b1};
        g[4] = '{1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,     5'd1, 5'b00001, 1'b1};
        g[5] = '{1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,     5'd3, 5'b00011, 1'b1};
        g[6] = '{1'b1, 5'd0, 1'b1, 5'd20, 1'b0, 1'b1, 5'b00001, 5'd7, 5'b00111, 1'b0};
        g[7] = '{1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,     5'd2, 5'b00010, 1'b0};
        g[8] = '{1'b1, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, 5'b11111, 5'd4, 5'b00100, 1'b0};
        g[9] = '{1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,     5'd8, 5'b01000, 1'b0};
        for (int s = 0; s < 10; s++) begin
            drive(1, g[s].lv, g[s].pc, g[s].uv, g[s].ui, g[s].ut, g[s].um, g[s].ug);
            @(negedge clk);
            if (g[s].lv) begin
                read_out(1, pv, pt, pi, pg, rdy);
                pop_exp(1, e, ok);
                n_checks++;
                if (!ok || pv !== 1'b1 || pt !== g[s].exp_tk || pi !== g[s].exp_idx || pg !== g[s].exp_ghr || pg !== e.ghr) begin
                    n_fail++;
                    $display("FAIL gshare step %0d: got v=%b t=%b idx=%0d ghr=%b, want v=1 t=%b idx=%0d ghr=%b", s, pv, pt, pi, pg, g[s].exp_tk, g[s].exp_idx, g[s].exp_ghr);
                end
            end
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_rst_restart();
        logic pv, pt, rdy;
        logic [4:0] pi, pg;
        exp_t e;
        bit ok;
        int cycles;
        // In-flight lookup is dropped by a reset during RUN.
        drive(0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if_a.pred_valid !== 1'b0 || if_a.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_run: got v=%b rdy=%b, want 0 0", if_a.pred_valid, if_a.ready);
        end
        idle_all();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (if_a.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_sweep_ready: got %b, want 0", if_a.ready);
        end
        reset_and_count(1, cycles);
        n_checks++;
        if (cycles != 32) begin
            n_fail++;
            $display("FAIL restart_sweep_len: got %0d cycles, want 32", cycles);
        end
        // Previously trained entries must be back to weakly-not-taken.
        for (int d = 0; d < 3; d += 2) begin
            drive(d, 1'b1, (d == 0) ? 5'd8 : 5'd10, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
            idle_all();
            read_out(d, pv, pt, pi, pg, rdy);
            pop_exp(d, e, ok);
            n_checks++;
            if (!ok || pv !== 1'b1 || pt !== 1'b0 || pi !== e.idx || pg !== 5'd0) begin
                n_fail++;
                $display("FAIL cleared_after_rst dut%0d: got v=%b t=%b idx=%0d ghr=%b, want v=1 t=0 idx=%0d ghr=0", d, pv, pt, pi, pg, e.idx);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        model_reset();
        idle_all();
        test_reset();
        test_first_lookup();
        test_train();
        test_bypass();
        test_gshare();
        test_cnt3();
        test_rst_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want completion");
        $fatal(1, "timeout");
    end

endmodule
